mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between instruction fetch (IF) and the data load/store path. The data path is driven by the controller's mem_write_enable, bit_half_word_select and is_unsigned outputs.
- Arbitrates the two requesters and sequences each access as one outstanding transaction.
- Generates byte enables and replicated write data; sign- or zero-extends load data.
- Flags misaligned data accesses without touching memory.

Parameters:
- MAX_DATA_STREAK, 4, number of consecutive contended data grants before fetch is forced one grant (1..15).
- ADDR_WIDTH, 32, byte-address width for both requesters and the memory port.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request; held until accepted
- if_addr  in  ADDR_WIDTH  fetch byte address (word access)
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction word
- d_req_valid  in  1  data request; held until accepted
- d_addr  in  ADDR_WIDTH  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  32  store data, right-aligned
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend load when 1
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  extended load data (0 for stores and errors)
- d_misaligned  out  1  valid with d_resp_valid; access was not performed
- mem_req  out  1  memory request, held until mem_ack
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[W-1:2],2'b00})
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory done; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read word

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; streak counter=0.
  - All outputs 0, including rdata, mem_addr, mem_be and mem_wdata.
  - An in-flight transaction is dropped; no response is issued after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is combinational from the request valids. Exactly one of if_req_ready/d_req_ready is asserted, and only for a valid requester.
  - Only one requester valid: grant it.
  - Both valid: grant data unless streak==MAX_DATA_STREAK, in which case grant fetch.
  - On a grant, register addr/we/wdata/size/unsigned and the owner.
  - Data granted: go to RESP with the error flag set if misaligned, otherwise go to ACCESS.
  - Fetch granted: go to ACCESS. Fetch addr[1:0] is ignored (word forced).
- Streak counter:
  - Increments (saturating) on a data grant while if_req_valid=1.
  - Clears on any fetch grant.
  - Unchanged on an uncontended data grant.
- ACCESS:
  - mem_req=1; mem_addr/mem_we/mem_be/mem_wdata stay stable until mem_ack.
  - On mem_ack, capture the processed read data, drop mem_req in the next cycle, go to RESP.
  - No timeout.
- RESP:
  - Pulse the owner's resp_valid for exactly one cycle, then go to IDLE. No grant is given in RESP.
  - if_rdata/d_rdata hold their value until the next response.
- Minimum latency: grant at T, mem_req from T+1, ack at T+1, resp at T+2. Back-to-back throughput is one access per 3 cycles.
- Misalignment rules (off=d_addr[1:0]):
  - Half access with off[0]=1 is misaligned.
  - Word access with off!=0 is misaligned.
  - d_size=11 is misaligned.
  - Error response: d_misaligned=1, d_rdata=0, no mem_req issued.
- Store lane handling:
  - Byte: be=0001<<off, wdata={4{b}}.
  - Half: be=0011<<off, wdata={2{h}}.
  - Word: be=1111.
  - mem_we=d_we.
- Load lane handling:
  - be is generated as for stores; mem_we=0.
  - Select byte mem_rdata[8*off+:8] or half mem_rdata[8*off+:16].
  - Extend to 32 bits: sign-extend if d_unsigned=0, zero-extend if 1.
  - Word loads ignore d_unsigned.
- Fetch: be=1111, mem_we=0, if_rdata=mem_rdata.
- Store completion: d_resp_valid pulses with d_rdata=0.
- Requests must not change while valid and not ready; behaviour is undefined otherwise.

Test Plan:
- Reset mid-ACCESS (d load pending, rst_n low 1 cycle) -> all outputs 0 next sample; the later mem_ack is ignored; no d_resp_valid.
- LB d_addr=0x103, mem_rdata=0x80FF_1234, d_unsigned=0 -> mem_addr=0x100, mem_be=1000, d_rdata=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH d_addr=0x202, d_wdata=0x1234_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1; response 1 cycle after ack with d_rdata=0.
- LW d_addr=0x301 -> d_misaligned=1, d_resp_valid at T+1, mem_req never asserted.
- Both requesters continuously valid, MAX_DATA_STREAK=4, ack at T+1 -> grant order D,D,D,D,F,D,D,D,D,F; streak clears on each F.
- Fetch only, mem_ack delayed 5 cycles -> mem_req held with stable mem_addr/mem_be=1111 for 5 cycles; if_resp_valid one cycle after ack with if_rdata=mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and data load/store
// Grants one requester at a time, sequences one outstanding access, lane-maps stores and extends loads.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [31:0]           d_wdata,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [31:0]           d_rdata,
  output logic                  d_misaligned,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t                state, state_next;
  logic   [3:0]          streak;
  logic                  owner_d;
  logic   [1:0]          r_size;
  logic   [1:0]          r_off;
  logic                  r_unsigned;

  logic                  grant_d, grant_f;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            d_off;
  logic                  d_mis;
  logic [3:0]            d_be;
  logic [31:0]           d_wlanes;
  logic [31:0]           shifted;
  logic [31:0]           load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Fetch wins a contended IDLE cycle only once data has taken MAX_DATA_STREAK grants in a row.
  always_comb begin
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req_valid && (!if_req_valid || streak != STREAK_MAX)) grant_d = 1'b1;
        else if (if_req_valid)                                      grant_f = 1'b1;
        if (grant_d)      state_next = d_mis ? RESP : ACCESS;
        else if (grant_f) state_next = ACCESS;
      end
      ACCESS:  if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign if_req_ready  = grant_f;
  assign d_req_ready   = grant_d;
  assign mem_req       = (state == ACCESS);
  assign if_resp_valid = (state == RESP) && !owner_d;
  assign d_resp_valid  = (state == RESP) && owner_d;

  assign sel_addr = grant_f ? if_addr : d_addr;
  assign d_off    = d_addr[1:0];

  always_comb begin
    d_mis    = 1'b0;
    d_be     = 4'b0000;
    d_wlanes = 32'h0;
    case (d_size)
      2'b00: begin
        d_be     = 4'b0001 << d_off;
        d_wlanes = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_mis    = d_off[0];
        d_be     = 4'b0011 << d_off;
        d_wlanes = {2{d_wdata[15:0]}};
      end
      2'b10: begin
        d_mis    = |d_off;
        d_be     = 4'b1111;
        d_wlanes = d_wdata;
      end
      default: d_mis = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend according to the captured size.
  assign shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (r_size)
      2'b00:   load_data = r_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = r_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d      <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_unsigned   <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0;
      d_rdata      <= 32'h0;
      d_misaligned <= 1'b0;
      if_rdata     <= 32'h0;
    end else begin
      if (grant_d || grant_f) begin
        owner_d    <= grant_d;
        r_size     <= d_size;
        r_unsigned <= d_unsigned;
        r_off      <= grant_d ? sel_addr[1:0] : 2'b00;
        mem_addr   <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_we     <= grant_d & d_we;
        mem_be     <= grant_d ? d_be : 4'b1111;
        mem_wdata  <= grant_d ? d_wlanes : 32'h0;
        if (grant_d && d_mis) begin
          d_rdata      <= 32'h0;
          d_misaligned <= 1'b1;
        end
      end
      // Response data lands on the same edge that enters RESP, so it holds until the next response.
      if (state == ACCESS && mem_ack) begin
        if (owner_d) begin
          d_rdata      <= mem_we ? 32'h0 : load_data;
          d_misaligned <= 1'b0;
        end else begin
          if_rdata     <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  streak <= 4'd0;
    else if (grant_f)                                            streak <= 4'd0;
    else if (grant_d && if_req_valid && streak != STREAK_MAX)    streak <= streak + 4'd1;
  end

endmodule
